// File: rtl/shift_reg_pkg.sv
// Shared types for the universal shift register.
// Operation codes, burst FSM states and op classification.
package shift_reg_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_LOAD = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_ROL  = 3'd4,
        OP_ROR  = 3'd5,
        OP_ASR  = 3'd6,
        OP_RSV  = 3'd7
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic is_shift_op(op_e op);
        return (op == OP_SHL) || (op == OP_SHR) ||
               (op == OP_ROL) || (op == OP_ROR) ||
               (op == OP_ASR);
    endfunction

endpackage

// File: rtl/shift_reg_step.sv
// Combinational one-step shifter/rotator.
// Non-shift ops pass the register through unchanged.
import shift_reg_pkg::*;

module shift_reg_step #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] out,
    input  logic [STEP-1:0]  din,
    output logic [WIDTH-1:0] next_out,
    output logic [STEP-1:0]  next_sout
);

    logic [STEP-1:0] hi;
    logic [STEP-1:0] lo;
    logic [STEP-1:0] sign_fill;

    assign hi        = out[WIDTH-1:WIDTH-STEP];
    assign lo        = out[STEP-1:0];
    assign sign_fill = {STEP{out[WIDTH-1]}};

    always_comb begin
        next_out  = out;
        next_sout = '0;
        unique case (op)
            OP_SHL: begin
                next_out  = {out[WIDTH-STEP-1:0], din};
                next_sout = hi;
            end
            OP_SHR: begin
                next_out  = {din, out[WIDTH-1:STEP]};
                next_sout = lo;
            end
            OP_ROL: begin
                next_out  = {out[WIDTH-STEP-1:0], hi};
                next_sout = hi;
            end
            OP_ROR: begin
                next_out  = {lo, out[WIDTH-1:STEP]};
                next_sout = lo;
            end
            OP_ASR: begin
                next_out  = {sign_fill, out[WIDTH-1:STEP]};
                next_sout = lo;
            end
            default: begin
                next_out  = out;
                next_sout = '0;
            end
        endcase
    end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register with parallel load and counted bursts.
// Bursts replay a latched shift op; done pulses once at completion.
import shift_reg_pkg::*;

module shift_reg_univ #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [STEP-1:0]  din,
    input  logic [WIDTH-1:0] pdata,
    input  logic             start,
    input  logic [CNT_W-1:0] cnt,
    output logic [WIDTH-1:0] out,
    output logic [STEP-1:0]  sout,
    output logic             busy,
    output logic             done
);

    state_e           state;
    state_e           state_nxt;
    op_e              op_in;
    op_e              op_sel;
    op_e              lat_op;
    op_e              lat_nxt;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] rem_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic [STEP-1:0]  sout_nxt;
    logic             done_nxt;
    logic [WIDTH-1:0] step_out;
    logic [STEP-1:0]  step_sout;

    assign op_in  = op_e'(op);
    assign op_sel = (state == RUN) ? lat_op : op_in;
    assign busy   = (state == RUN);

    shift_reg_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .op        (op_sel),
        .out       (out),
        .din       (din),
        .next_out  (step_out),
        .next_sout (step_sout)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= IDLE;
            lat_op <= OP_HOLD;
            rem    <= '0;
            out    <= '0;
            sout   <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            lat_op <= lat_nxt;
            rem    <= rem_nxt;
            out    <= out_nxt;
            sout   <= sout_nxt;
            done   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lat_nxt   = lat_op;
        rem_nxt   = rem;
        out_nxt   = out;
        sout_nxt  = sout;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (en) begin
                    if (start && is_shift_op(op_in)) begin
                        // zero-length burst completes at once
                        if (cnt != '0) begin
                            state_nxt = RUN;
                            rem_nxt   = cnt;
                            lat_nxt   = op_in;
                        end else begin
                            done_nxt  = 1'b1;
                        end
                    end else if (op_in == OP_LOAD) begin
                        out_nxt = pdata;
                    end else if (is_shift_op(op_in)) begin
                        out_nxt  = step_out;
                        sout_nxt = step_sout;
                    end
                end
            end
            RUN: begin
                if (en) begin
                    out_nxt  = step_out;
                    sout_nxt = step_sout;
                    rem_nxt  = rem - CNT_W'(1);
                    if (rem == CNT_W'(1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench: directed scenarios plus random traffic,
// compared each cycle against an arithmetic reference model.
module tb_shift_reg_univ;

    localparam int W = 8;
    localparam int S = 1;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rstn;
    logic         en;
    logic [2:0]   op;
    logic [S-1:0] din;
    logic [W-1:0] pdata;
    logic         start;
    logic [C-1:0] cnt;
    logic [W-1:0] out;
    logic [S-1:0] sout;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] m_out;
    logic [S-1:0] m_sout;
    logic         m_busy;
    logic         m_done;
    int           m_rem;
    logic [2:0]   m_op;

    shift_reg_univ #(.WIDTH(W), .STEP(S), .CNT_W(C)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .en    (en),
        .op    (op),
        .din   (din),
        .pdata (pdata),
        .start (start),
        .cnt   (cnt),
        .out   (out),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_sh(logic [2:0] o);
        return o >= 3'd2 && o <= 3'd6;
    endfunction

    task automatic ref_apply(input logic [2:0] o);
        logic [W+S-1:0] cat;
        logic [2*W-1:0] dbl;
        dbl = {m_out, m_out};
        case (o)
            3'd1: m_out = pdata;
            3'd2: begin
                cat    = {m_out, din};
                m_sout = m_out[W-1 -: S];
                m_out  = cat[W-1:0];
            end
            3'd3: begin
                cat    = {din, m_out} >> S;
                m_sout = m_out[S-1:0];
                m_out  = cat[W-1:0];
            end
            3'd4: begin
                dbl    = dbl << S;
                m_sout = m_out[W-1 -: S];
                m_out  = dbl[2*W-1:W];
            end
            3'd5: begin
                dbl    = dbl >> S;
                m_sout = m_out[S-1:0];
                m_out  = dbl[W-1:0];
            end
            3'd6: begin
                m_sout = m_out[S-1:0];
                m_out  = $signed(m_out) >>> S;
            end
            default: ;
        endcase
    endtask

    task automatic ref_edge();
        logic d;
        if (!rstn) begin
            m_out  = '0;
            m_sout = '0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_rem  = 0;
            return;
        end
        d = 1'b0;
        if (en) begin
            if (!m_busy) begin
                if (start && is_sh(op)) begin
                    if (cnt != 0) begin
                        m_busy = 1'b1;
                        m_rem  = int'(cnt);
                        m_op   = op;
                    end else begin
                        d = 1'b1;
                    end
                end else begin
                    ref_apply(op);
                end
            end else begin
                ref_apply(m_op);
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 1'b0;
                    d      = 1'b1;
                end
            end
        end
        m_done = d;
    endtask

    task automatic tick();
        @(posedge clk);
        ref_edge();
        #1;
        chk("out", 32'(out), 32'(m_out));
        chk("sout", 32'(sout), 32'(m_sout));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
    endtask

    task automatic drv(input logic r, input logic e, input logic [2:0] o,
                       input logic s, input int c, input logic d,
                       input logic [W-1:0] p);
        rstn  = r;
        en    = e;
        op    = o;
        start = s;
        cnt   = C'(c);
        din   = d;
        pdata = p;
    endtask

    initial begin
        m_out = '0; m_sout = '0; m_busy = 0; m_done = 0;
        m_rem = 0; m_op = 3'd0;
        drv(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();

        // reset overrides an in-flight burst
        drv(1, 1, 1, 0, 0, 0, 8'hFF); tick();
        drv(1, 1, 2, 1, 5, 0, 0);     tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        drv(0, 1, 0, 0, 0, 0, 0);     tick();
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        drv(1, 1, 1, 0, 0, 0, 8'hA5); tick();
        chk("load", 32'(out), 32'hA5);
        drv(1, 1, 2, 0, 0, 1, 0);     tick();
        chk("shl", 32'(out), 32'h4B);
        chk("shl_sout", 32'(sout), 32'd1);

        drv(1, 1, 1, 0, 0, 0, 8'hA5); tick();
        drv(1, 1, 5, 1, 3, 0, 0);     tick();
        chk("ror_acc", 32'(out), 32'hA5);
        drv(1, 1, 0, 0, 0, 0, 0);
        tick(); chk("ror1", 32'(out), 32'hD2);
        tick(); chk("ror2", 32'(out), 32'h69);
        tick(); chk("ror3", 32'(out), 32'hB4);
        chk("ror_done", 32'(done), 32'd1);
        tick(); chk("ror_done0", 32'(done), 32'd0);

        drv(1, 1, 1, 0, 0, 0, 8'h90); tick();
        drv(1, 1, 6, 1, 2, 1, 0);     tick();
        drv(1, 1, 0, 0, 0, 1, 0);
        tick(); chk("asr1", 32'(out), 32'hC8);
        tick(); chk("asr2", 32'(out), 32'hE4);
        chk("asr_sout", 32'(sout), 32'd0);
        drv(1, 1, 6, 1, 0, 0, 0);     tick();
        chk("cnt0_done", 32'(done), 32'd1);
        chk("cnt0_busy", 32'(busy), 32'd0);
        chk("cnt0_out", 32'(out), 32'hE4);
        drv(1, 1, 0, 0, 0, 0, 0);     tick();

        drv(1, 1, 1, 0, 0, 0, 8'hFF); tick();
        drv(1, 1, 3, 1, 4, 0, 0);     tick();
        drv(1, 1, 0, 0, 0, 0, 0);
        tick(); chk("shr1", 32'(out), 32'h7F);
        tick(); chk("shr2", 32'(out), 32'h3F);
        en = 0;
        tick(); tick();
        chk("stall", 32'(out), 32'h3F);
        chk("stall_busy", 32'(busy), 32'd1);
        en = 1;
        tick(); chk("shr3", 32'(out), 32'h1F);
        tick(); chk("shr4", 32'(out), 32'h0F);
        chk("shr_done", 32'(done), 32'd1);
        tick();

        drv(1, 1, 1, 0, 0, 0, 8'h81); tick();
        drv(1, 1, 4, 1, 5, 0, 0);     tick();
        drv(1, 1, 0, 0, 0, 0, 0);
        tick(); chk("rol1", 32'(out), 32'h03);
        tick(); chk("rol2", 32'(out), 32'h06);
        drv(0, 1, 0, 0, 0, 0, 0);     tick();
        chk("mid_rst", 32'(out), 32'h0);
        drv(1, 1, 0, 0, 0, 0, 0);     tick();
        chk("mid_rst_done", 32'(done), 32'd0);
        drv(1, 1, 1, 0, 0, 0, 8'h3C); tick();
        chk("post_rst_load", 32'(out), 32'h3C);

        for (int i = 0; i < 600; i++) begin
            drv(($urandom_range(0, 49) != 0),
                ($urandom_range(0, 4) != 0),
                3'($urandom_range(0, 7)),
                ($urandom_range(0, 2) == 0),
                int'($urandom_range(0, 5)),
                1'($urandom),
                W'($urandom));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
